// File: rtl/issue_scheduler.sv
// Issue scheduler: grants one queue head per cycle so that no two results
// collide on the common data bus, and blocks the divider while it is busy.
module issue_scheduler #(
    parameter int INT_LAT  = 1,
    parameter int LDST_LAT = 2,
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_flush,
    input  logic       i_int_ready,
    input  logic       i_ldst_ready,
    input  logic       i_mult_ready,
    input  logic       i_div_ready,
    output logic       o_int_issue,
    output logic       o_ldst_issue,
    output logic       o_mult_issue,
    output logic       o_div_issue,
    output logic       o_div_busy,
    output logic       o_cdb_valid,
    output logic [1:0] o_cdb_sel
);
    localparam int M1     = (INT_LAT > LDST_LAT) ? INT_LAT : LDST_LAT;
    localparam int M2     = (M1 > MULT_LAT) ? M1 : MULT_LAT;
    localparam int MAXLAT = (M2 > DIV_LAT) ? M2 : DIV_LAT;
    localparam int CW     = $clog2(DIV_LAT + 1);

    typedef struct packed {
        logic       v;
        logic [1:0] own;
    } slot_t;

    slot_t         slot_q [MAXLAT+1];
    slot_t         slot_d [MAXLAT+1];
    logic [CW-1:0] div_cnt_q, div_cnt_d;
    logic          lru_q, lru_d;
    logic [3:0]    gnt;
    logic          int_el, ldst_el, mult_el, div_el;

    assign int_el  = i_int_ready  && !slot_q[INT_LAT].v;
    assign ldst_el = i_ldst_ready && !slot_q[LDST_LAT].v;
    assign mult_el = i_mult_ready && !slot_q[MULT_LAT].v;
    assign div_el  = i_div_ready  && !slot_q[DIV_LAT].v
                     && (div_cnt_q == '0);

    // gnt bit index doubles as the CDB owner code
    always_comb begin
        gnt = '0;
        if (i_rst_n && !i_flush) begin
            if (div_el)
                gnt[3] = 1'b1;
            else if (mult_el)
                gnt[2] = 1'b1;
            else if (int_el && (!lru_q || !ldst_el))
                gnt[0] = 1'b1;
            else if (ldst_el)
                gnt[1] = 1'b1;
        end
    end

    always_comb begin
        for (int j = 0; j < MAXLAT; j++)
            slot_d[j] = slot_q[j+1];
        slot_d[MAXLAT] = '0;
        if (gnt[0]) slot_d[INT_LAT-1]  = {1'b1, 2'd0};
        if (gnt[1]) slot_d[LDST_LAT-1] = {1'b1, 2'd1};
        if (gnt[2]) slot_d[MULT_LAT-1] = {1'b1, 2'd2};
        if (gnt[3]) slot_d[DIV_LAT-1]  = {1'b1, 2'd3};
    end

    always_comb begin
        div_cnt_d = div_cnt_q;
        if (gnt[3])
            div_cnt_d = CW'(DIV_LAT);
        else if (div_cnt_q != '0)
            div_cnt_d = div_cnt_q - CW'(1);
    end

    always_comb begin
        lru_d = lru_q;
        if (gnt[0])
            lru_d = 1'b1;
        else if (gnt[1])
            lru_d = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int j = 0; j <= MAXLAT; j++)
                slot_q[j] <= '0;
            div_cnt_q <= '0;
            lru_q     <= 1'b0;
        end else begin
            for (int j = 0; j <= MAXLAT; j++)
                slot_q[j] <= slot_d[j];
            div_cnt_q <= div_cnt_d;
            lru_q     <= lru_d;
        end
    end

    assign o_int_issue  = gnt[0];
    assign o_ldst_issue = gnt[1];
    assign o_mult_issue = gnt[2];
    assign o_div_issue  = gnt[3];
    assign o_div_busy   = (div_cnt_q != '0);
    assign o_cdb_valid  = slot_q[0].v;
    assign o_cdb_sel    = slot_q[0].own;
endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: vector table plus a CDB booking
// scoreboard and a second instance with equal int/ldst latency.
module tb_issue_scheduler;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic [3:0] rdy = '0;

    logic [3:0] iss0, iss1;
    logic       busy0, cv0, busy1, cv1;
    logic [1:0] sel0, sel1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    issue_scheduler u0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
        .i_int_ready(rdy[0]), .i_ldst_ready(rdy[1]),
        .i_mult_ready(rdy[2]), .i_div_ready(rdy[3]),
        .o_int_issue(iss0[0]), .o_ldst_issue(iss0[1]),
        .o_mult_issue(iss0[2]), .o_div_issue(iss0[3]),
        .o_div_busy(busy0), .o_cdb_valid(cv0), .o_cdb_sel(sel0)
    );

    issue_scheduler #(.INT_LAT(1), .LDST_LAT(1)) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
        .i_int_ready(rdy[0]), .i_ldst_ready(rdy[1]),
        .i_mult_ready(rdy[2]), .i_div_ready(rdy[3]),
        .o_int_issue(iss1[0]), .o_ldst_issue(iss1[1]),
        .o_mult_issue(iss1[2]), .o_div_issue(iss1[3]),
        .o_div_busy(busy1), .o_cdb_valid(cv1), .o_cdb_sel(sel1)
    );

    typedef struct {
        string    name;
        bit       rst_n;
        bit       flush;
        bit [3:0] rdy;
        bit [3:0] iss;
        bit       busy;
        bit       cv;
        bit [1:0] sel;
    } vec_t;

    vec_t tv[$];

    function automatic void add(string n, bit r, bit f, bit [3:0] rd,
                                bit [3:0] is, bit b, bit v, bit [1:0] s);
        vec_t e;
        e.name = n; e.rst_n = r; e.flush = f; e.rdy = rd;
        e.iss = is; e.busy = b; e.cv = v; e.sel = s;
        tv.push_back(e);
    endfunction

    // Scoreboard: books the CDB from observed grants of u0
    int       lat[4] = '{1, 2, 4, 8};
    bit       mv[9];
    bit [1:0] mo[9];

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int j = 0; j < 9; j++) begin
                mv[j] = 1'b0;
                mo[j] = 2'd0;
            end
        end else begin
            checks++;
            if (cv0 !== mv[0] || (mv[0] && sel0 !== mo[0])) begin
                errors++;
                $display("FAIL sb_cdb t=%0t got v=%0b sel=%0d exp v=%0b sel=%0d",
                         $time, cv0, sel0, mv[0], mo[0]);
            end
            checks++;
            if ($countones(iss0) > 1) begin
                errors++;
                $display("FAIL onehot t=%0t got %b exp at most one grant",
                         $time, iss0);
            end
            for (int u = 0; u < 4; u++) begin
                if (iss0[u]) begin
                    if (mv[lat[u]]) begin
                        errors++;
                        $display("FAIL dup_book t=%0t unit %0d slot %0d already owner %0d",
                                 $time, u, lat[u], mo[lat[u]]);
                    end
                    mv[lat[u]] = 1'b1;
                    mo[lat[u]] = 2'(u);
                end
            end
            for (int j = 0; j < 8; j++) begin
                mv[j] = mv[j+1];
                mo[j] = mo[j+1];
            end
            mv[8] = 1'b0;
            mo[8] = 2'd0;
        end
    end

    task automatic chk(string n, bit [7:0] got, bit [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got iss/busy/v/sel=%b exp %b",
                     n, $time, got, exp);
        end
    endtask

    initial begin
        // test 1: int streaming
        add("rst1", 0, 0, 4'h0, 4'h0, 0, 0, 2'd0);
        for (int c = 0; c < 12; c++)
            add("t1", 1, 0, (c <= 9) ? 4'h1 : 4'h0, (c <= 9) ? 4'h1 : 4'h0,
                0, (c >= 1 && c <= 10), 2'd0);
        // test 2: mult booking blocks int
        add("rst2", 0, 0, 4'h0, 4'h0, 0, 0, 2'd0);
        for (int c = 0; c < 8; c++)
            add("t2", 1, 0,
                (c == 0) ? 4'h4 : (c == 3 || c == 4) ? 4'h1 : 4'h0,
                (c == 0) ? 4'h4 : (c == 4) ? 4'h1 : 4'h0,
                0, (c == 4 || c == 5), (c == 4) ? 2'd2 : 2'd0);
        // test 3: back-to-back div
        add("rst3", 0, 0, 4'h0, 4'h0, 0, 0, 2'd0);
        for (int c = 0; c < 18; c++)
            add("t3", 1, 0, 4'h8, (c == 0 || c == 9) ? 4'h8 : 4'h0,
                (c != 0 && c != 9), (c == 8 || c == 17), (c == 8 || c == 17) ? 2'd3 : 2'd0);
        // test 5: div beats mult, mult follows
        add("rst5", 0, 0, 4'h0, 4'h0, 0, 0, 2'd0);
        for (int c = 0; c < 10; c++)
            add("t5", 1, 0,
                (c == 0) ? 4'hC : (c == 1) ? 4'h4 : 4'h0,
                (c == 0) ? 4'h8 : (c == 1) ? 4'h4 : 4'h0,
                (c >= 1 && c <= 8), (c == 5 || c == 8),
                (c == 5) ? 2'd2 : (c == 8) ? 2'd3 : 2'd0);
        // test 6 prefix: flush, then a div to be interrupted by reset
        add("rst6", 0, 0, 4'h0, 4'h0, 0, 0, 2'd0);
        add("t6_c0", 1, 0, 4'h1, 4'h1, 0, 0, 2'd0);
        add("t6_flush", 1, 1, 4'h1, 4'h0, 0, 1, 2'd0);
        add("t6_c2", 1, 0, 4'h8, 4'h8, 0, 0, 2'd0);
        add("t6_c3", 1, 0, 4'h0, 4'h0, 1, 0, 2'd0);
        add("t6_c4", 1, 0, 4'h0, 4'h0, 1, 0, 2'd0);

        for (int i = 0; i < tv.size(); i++) begin
            @(posedge clk);
            #1;
            rst_n = tv[i].rst_n;
            flush = tv[i].flush;
            rdy   = tv[i].rdy;
            #3;
            chk(tv[i].name, {iss0, busy0, cv0, sel0},
                {tv[i].iss, tv[i].busy, tv[i].cv, tv[i].sel});
        end

        // test 6 tail: async reset while the divider is busy
        @(posedge clk);
        #1;
        chk("t6_busy_before", {iss0, busy0, cv0, sel0}, 8'b0000_1000);
        rst_n = 1'b0;
        rdy   = 4'hF;
        #1;
        chk("t6_async_rst", {iss0, busy0, cv0, sel0}, 8'h00);

        // test 4: equal int/ldst latency alternates via LRU (u1)
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        rdy   = 4'h0;
        #3;
        chk("t4_rst", {iss1, busy1, cv1, sel1}, 8'h00);
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            rdy   = 4'h3;
            #3;
            chk("t4_alt", {iss1, busy1, cv1, sel1},
                {(c % 2 == 0) ? 4'h1 : 4'h2, 1'b0, (c >= 1),
                 (c >= 1) ? 2'((c - 1) % 2) : 2'd0});
        end

        @(posedge clk);
        #1;
        rdy = 4'h0;
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
